// File: rtl/trap_seq_if.sv
// CSR file single access port: one address, write/read enables, write data and
// combinational read data returned by the CSR file.
interface trap_seq_if #(
    parameter int unsigned DATA_LEN = 32
);
    logic                wen;
    logic                ren;
    logic [11:0]         addr;
    logic [DATA_LEN-1:0] wdata;
    logic [DATA_LEN-1:0] rdata;

    modport master (
        output wen,
        output ren,
        output addr,
        output wdata,
        input  rdata
    );

    modport slave (
        input  wen,
        input  ren,
        input  addr,
        input  wdata,
        output rdata
    );
endinterface

// File: rtl/trap_seq.sv
// Trap entry / mret sequencer and arbiter for the machine-mode CSR access port.
// Defining TRAP_MTVAL_EN adds a trap_tval input and an mtval write during trap entry.
module trap_seq #(
    parameter int unsigned DATA_LEN = 32
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                trap_req,
    input  logic [DATA_LEN-1:0] trap_cause,
    input  logic [DATA_LEN-1:0] trap_pc,
`ifdef TRAP_MTVAL_EN
    input  logic [DATA_LEN-1:0] trap_tval,
`endif
    input  logic                mret_req,

    input  logic                inst_wen,
    input  logic                inst_ren,
    input  logic [11:0]         inst_addr,
    input  logic [DATA_LEN-1:0] inst_wdata,
    output logic [DATA_LEN-1:0] inst_rdata,
    output logic                inst_ready,

    trap_seq_if.master          csr,

    output logic                busy,
    output logic                redirect_valid,
    output logic [DATA_LEN-1:0] redirect_pc
);

    localparam logic [11:0] ADDR_MSTATUS = 12'h300;
    localparam logic [11:0] ADDR_MTVEC   = 12'h305;
    localparam logic [11:0] ADDR_MEPC    = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
`ifdef TRAP_MTVAL_EN
    localparam logic [11:0] ADDR_MTVAL   = 12'h343;
`endif

    typedef enum logic [2:0] {
        StIdle,
        StTEpc,
        StTCause,
`ifdef TRAP_MTVAL_EN
        StTTval,
`endif
        StTStat,
        StTVec,
        StRStat,
        StREpc
    } state_e;

    state_e              state_q;
    logic [DATA_LEN-1:0] cause_q;
    logic [DATA_LEN-1:0] pc_q;
`ifdef TRAP_MTVAL_EN
    logic [DATA_LEN-1:0] tval_q;
`endif
    logic                idle_pass;

    // Trap entry: stash MIE into MPIE, disable interrupts, record M-mode as previous.
    function automatic logic [DATA_LEN-1:0] trap_mstatus(input logic [DATA_LEN-1:0] s);
        logic [DATA_LEN-1:0] r;
        r       = s;
        r[7]    = s[3];
        r[3]    = 1'b0;
        r[12:11] = 2'b11;
        return r;
    endfunction

    function automatic logic [DATA_LEN-1:0] mret_mstatus(input logic [DATA_LEN-1:0] s);
        logic [DATA_LEN-1:0] r;
        r        = s;
        r[3]     = s[7];
        r[7]     = 1'b1;
        r[12:11] = 2'b11;
        return r;
    endfunction

    assign idle_pass = (state_q == StIdle) && !trap_req && !mret_req;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= StIdle;
            busy           <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            cause_q        <= '0;
            pc_q           <= '0;
`ifdef TRAP_MTVAL_EN
            tval_q         <= '0;
`endif
        end else begin
            redirect_valid <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (trap_req) begin
                        cause_q <= trap_cause;
                        pc_q    <= trap_pc;
`ifdef TRAP_MTVAL_EN
                        tval_q  <= trap_tval;
`endif
                        state_q <= StTEpc;
                        busy    <= 1'b1;
                    end else if (mret_req) begin
                        state_q <= StRStat;
                        busy    <= 1'b1;
                    end
                end
                StTEpc: state_q <= StTCause;
`ifdef TRAP_MTVAL_EN
                StTCause: state_q <= StTTval;
                StTTval:  state_q <= StTStat;
`else
                StTCause: state_q <= StTStat;
`endif
                StTStat: state_q <= StTVec;
                StTVec: begin
                    // Vector mode bits are ignored; always jump to the direct base.
                    redirect_pc    <= {csr.rdata[DATA_LEN-1:2], 2'b00};
                    redirect_valid <= 1'b1;
                    busy           <= 1'b0;
                    state_q        <= StIdle;
                end
                StRStat: state_q <= StREpc;
                StREpc: begin
                    redirect_pc    <= csr.rdata;
                    redirect_valid <= 1'b1;
                    busy           <= 1'b0;
                    state_q        <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

    // Address and enables depend only on state and the instruction request, never on
    // rdata, so the CSR file's combinational read path cannot form a loop.
    always_comb begin
        csr.wen    = 1'b0;
        csr.ren    = 1'b0;
        csr.addr   = '0;
        inst_ready = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (idle_pass) begin
                    csr.wen    = inst_wen;
                    csr.ren    = inst_ren;
                    csr.addr   = inst_addr;
                    inst_ready = 1'b1;
                end
            end
            StTEpc: begin
                csr.wen  = 1'b1;
                csr.addr = ADDR_MEPC;
            end
            StTCause: begin
                csr.wen  = 1'b1;
                csr.addr = ADDR_MCAUSE;
            end
`ifdef TRAP_MTVAL_EN
            StTTval: begin
                csr.wen  = 1'b1;
                csr.addr = ADDR_MTVAL;
            end
`endif
            StTStat, StRStat: begin
                csr.wen  = 1'b1;
                csr.ren  = 1'b1;
                csr.addr = ADDR_MSTATUS;
            end
            StTVec: begin
                csr.ren  = 1'b1;
                csr.addr = ADDR_MTVEC;
            end
            StREpc: begin
                csr.ren  = 1'b1;
                csr.addr = ADDR_MEPC;
            end
            default: ;
        endcase
        // A reset landing mid-sequence must not let the in-flight write commit.
        if (rst && (state_q != StIdle)) begin
            csr.wen = 1'b0;
        end
    end

    always_comb begin
        csr.wdata  = '0;
        inst_rdata = '0;
        unique case (state_q)
            StIdle: begin
                if (idle_pass) begin
                    csr.wdata  = inst_wdata;
                    inst_rdata = csr.rdata;
                end
            end
            StTEpc:   csr.wdata = pc_q;
            StTCause: csr.wdata = cause_q;
`ifdef TRAP_MTVAL_EN
            StTTval:  csr.wdata = tval_q;
`endif
            StTStat:  csr.wdata = trap_mstatus(csr.rdata);
            StRStat:  csr.wdata = mret_mstatus(csr.rdata);
            default: ;
        endcase
    end

endmodule
